// File: rtl/poly_interp_fir.sv
// Polyphase interpolating FIR: L phases of TPP taps per input strobe, two-stage multiply/accumulate pipeline.
// Optional build macro POLY_INTERP_ROUND_EN selects round-half-up ahead of the output shift; otherwise floor.
module poly_interp_fir #(
   parameter int DW        = 18,
   parameter int CW        = 18,
   parameter int L         = 4,
   parameter int TPP       = 5,
   parameter int OUT_SHIFT = 17
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sam_clk_ena,
   input  logic signed [DW-1:0]         x_in,
   input  logic                         flush,
   input  logic                         coef_we,
   input  logic [$clog2(L*TPP)-1:0]     coef_addr,
   input  logic signed [CW-1:0]         coef_data,
   output logic signed [DW-1:0]         y,
   output logic                         out_valid
);

   localparam int NT  = L * TPP;
   localparam int AC  = $clog2(NT);
   localparam int PHW = (L > 4) ? $clog2(L) : 2;
   localparam int PW  = CW + DW;
   localparam int AW  = PW + $clog2(TPP);
   localparam int SW  = AW + 1;

   localparam logic [PHW-1:0]         PH_LAST = PHW'(L - 1);
   localparam logic [AC:0]            NT_W    = (AC + 1)'(NT);
   localparam logic signed [DW-1:0]   YMAX    = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0]   YMIN    = ~YMAX;
   localparam logic signed [SW-1:0]   SMAX    = SW'(YMAX);
   localparam logic signed [SW-1:0]   SMIN    = SW'(YMIN);
`ifdef POLY_INTERP_ROUND_EN
   localparam int unsigned            RND_SH  = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [SW-1:0]   RND_C   = (OUT_SHIFT > 0) ? (SW'(1) << RND_SH) : '0;
`endif

   typedef enum logic {IDLE, RUN} state_e;

   state_e                  state_q;
   logic [PHW-1:0]          ph_q;
   logic signed [DW-1:0]    x_q    [TPP];
   logic signed [CW-1:0]    h_q    [NT];
   logic signed [PW-1:0]    prod_d [TPP];
   logic signed [PW-1:0]    prod_q [TPP];
   logic                    v1_q;
   logic signed [DW-1:0]    y_q;
   logic signed [DW-1:0]    y_d;
   logic                    out_valid_q;
   logic signed [SW-1:0]    acc_s;
   logic signed [SW-1:0]    sh_s;
   logic                    issue;
   logic                    coef_ok;
   logic [AC-1:0]           hidx   [TPP];

   assign issue   = (state_q == RUN);
   assign coef_ok = ({1'b0, coef_addr} < NT_W);

   // Delay line: newest sample in x_q[0]
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < TPP; i++) x_q[i] <= '0;
      end else if (flush) begin
         for (int unsigned i = 0; i < TPP; i++) x_q[i] <= '0;
      end else if (sam_clk_ena) begin
         x_q[0] <= x_in;
         for (int unsigned i = 1; i < TPP; i++) x_q[i] <= x_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NT; i++) h_q[i] <= '0;
      end else if (coef_we && coef_ok) begin
         h_q[coef_addr] <= coef_data;
      end
   end

   // A strobe always restarts phase 0, dropping any unfinished phases of the previous sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ph_q    <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         ph_q    <= '0;
      end else if (sam_clk_ena) begin
         state_q <= RUN;
         ph_q    <= '0;
      end else if (state_q == RUN) begin
         if (ph_q == PH_LAST) begin
            state_q <= IDLE;
            ph_q    <= '0;
         end else begin
            ph_q    <= ph_q + 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < TPP; k++) begin
         hidx[k]   = AC'(k * L) + AC'(ph_q);
         prod_d[k] = PW'(h_q[hidx[k]]) * PW'(x_q[k]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q <= 1'b0;
         for (int unsigned k = 0; k < TPP; k++) prod_q[k] <= '0;
      end else if (flush) begin
         v1_q <= 1'b0;
         for (int unsigned k = 0; k < TPP; k++) prod_q[k] <= '0;
      end else begin
         v1_q <= issue;
         if (issue) begin
            for (int unsigned k = 0; k < TPP; k++) prod_q[k] <= prod_d[k];
         end
      end
   end

   // One spare bit above the accumulator absorbs the rounding offset
   always_comb begin
      acc_s = '0;
      for (int unsigned k = 0; k < TPP; k++) acc_s = acc_s + SW'(prod_q[k]);
`ifdef POLY_INTERP_ROUND_EN
      acc_s = acc_s + RND_C;
`endif
      sh_s = acc_s >>> OUT_SHIFT;
      if (sh_s > SMAX) begin
         y_d = YMAX;
      end else if (sh_s < SMIN) begin
         y_d = YMIN;
      end else begin
         y_d = sh_s[DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         y_q         <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= v1_q;
         if (v1_q) y_q <= y_d;
      end
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_poly_interp_fir.sv
// Bench for poly_interp_fir: two instances (OUT_SHIFT 0 and 17) share stimulus; a schedule-based
// reference predicts out_valid and y for every cycle.
module tb_poly_interp_fir;

   localparam int DW   = 18;
   localparam int CW   = 18;
   localparam int L    = 4;
   localparam int TPP  = 5;
   localparam int NT   = L * TPP;
   localparam int AWA  = $clog2(NT);
   localparam int MAXC = 6000;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b1;
   logic                  sam_clk_ena = 1'b0;
   logic                  flush = 1'b0;
   logic                  coef_we = 1'b0;
   logic signed [DW-1:0]  x_in = '0;
   logic [AWA-1:0]        coef_addr = '0;
   logic signed [CW-1:0]  coef_data = '0;
   logic signed [DW-1:0]  y0, y17;
   logic                  v0, v17;

   always #5 clk = ~clk;

   poly_interp_fir #(.DW(DW), .CW(CW), .L(L), .TPP(TPP), .OUT_SHIFT(0)) u_s0 (
      .clk(clk), .reset_n(reset_n), .sam_clk_ena(sam_clk_ena), .x_in(x_in), .flush(flush),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .y(y0), .out_valid(v0));

   poly_interp_fir #(.DW(DW), .CW(CW), .L(L), .TPP(TPP), .OUT_SHIFT(17)) u_s17 (
      .clk(clk), .reset_n(reset_n), .sam_clk_ena(sam_clk_ena), .x_in(x_in), .flush(flush),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .y(y17), .out_valid(v17));

   longint h_m [NT];
   longint x_m [TPP];
   bit     ev   [MAXC];
   longint ey0  [MAXC];
   longint ey17 [MAXC];
   longint held0, held17;
   int     cyc;
   int     n_cmp, n_err;
   bit     cap_en;
   int     cap_first;
   longint cap_q [$];

   function automatic longint sat(input longint v);
      longint mx, mn;
      mx = (longint'(1) <<< (DW - 1)) - 1;
      mn = -mx - 1;
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

   function automatic longint scale(input longint acc, input int sh);
      longint a;
      a = acc;
`ifdef POLY_INTERP_ROUND_EN
      if (sh > 0) a = a + (longint'(1) <<< (sh - 1));
`endif
      return sat(a >>> sh);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NT; i++) h_m[i] = 0;
      for (int k = 0; k < TPP; k++) x_m[k] = 0;
      for (int c = 0; c < MAXC; c++) ev[c] = 1'b0;
      held0  = 0;
      held17 = 0;
   endtask

   // Check outputs of the current cycle, apply this cycle's inputs to the model, advance one clock
   task automatic tick();
      longint acc;
      int     idx;
      @(negedge clk);
      if (ev[cyc]) begin
         held0  = ey0[cyc];
         held17 = ey17[cyc];
      end
      chk("valid_s0",  v0,  ev[cyc]);
      chk("valid_s17", v17, ev[cyc]);
      chk("y_s0",  y0,  held0);
      chk("y_s17", y17, held17);
      if (reset_n) begin
         if (coef_we && coef_addr < NT) h_m[coef_addr] = longint'(coef_data);
         if (flush) begin
            for (int k = 0; k < TPP; k++) x_m[k] = 0;
            for (int c = cyc + 1; c < MAXC; c++) ev[c] = 1'b0;
         end else if (sam_clk_ena) begin
            for (int k = TPP - 1; k > 0; k--) x_m[k] = x_m[k-1];
            x_m[0] = longint'(x_in);
            for (int p = 0; p < L; p++) begin
               acc = 0;
               for (int k = 0; k < TPP; k++) acc += h_m[k*L + p] * x_m[k];
               idx = cyc + 3 + p;
               if (idx < MAXC) begin
                  ev[idx]   = 1'b1;
                  ey0[idx]  = scale(acc, 0);
                  ey17[idx] = scale(acc, 17);
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      sam_clk_ena = 1'b0;
      flush       = 1'b0;
      coef_we     = 1'b0;
      if (cap_en && v0) begin
         if (cap_q.size() == 0) cap_first = cyc;
         cap_q.push_back(longint'(y0));
      end
   endtask

   task automatic strobe(input longint xv, input int gap);
      x_in        = xv[DW-1:0];
      sam_clk_ena = 1'b1;
      tick();
      repeat (gap - 1) tick();
   endtask

   task automatic wr(input int a, input longint d);
      coef_addr = AWA'(a);
      coef_data = d[CW-1:0];
      coef_we   = 1'b1;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      logic signed [DW-1:0] rv;
      int t0;
      n_cmp  = 0;
      n_err  = 0;
      cyc    = 0;
      cap_en = 1'b0;
      model_clear();

      #1 reset_n = 1'b0;
      #1;
      chk("rst_y_s0", y0, 0);
      chk("rst_v_s0", v0, 0);
      chk("rst_y_s17", y17, 0);
      chk("rst_v_s17", v17, 0);
      @(posedge clk);
      #1;
      idle(2);
      reset_n = 1'b1;
      idle(2);

      // Impulse through h[n] = n+1 on the unshifted instance
      for (int n = 0; n < NT; n++) wr(n, n + 1);
      for (int n = NT; n < (1 << AWA); n++) wr(n, 12345);
      idle(3);
      cap_en = 1'b1;
      t0 = cyc;
      strobe(1, 4);
      repeat (5) strobe(0, 4);
      idle(8);
      cap_en = 1'b0;
      chk("imp_first", cap_first, t0 + 3);
      chk("imp_count", cap_q.size(), 24);
      for (int i = 0; i < 24 && i < cap_q.size(); i++)
         chk($sformatf("imp_y%0d", i), cap_q[i], (i < 20) ? i + 1 : 0);

      // Early strobe: only phases 0,1 of the first sample survive
      strobe(100, 2);
      strobe(200, 4);
      idle(8);

      // Output holds when strobes stop, then flush and a clean impulse
      strobe(500, 4);
      strobe(-300, 4);
      idle(6);
      flush = 1'b1;
      tick();
      strobe(1, 4);
      idle(8);

      // Flush mid-run beats a coincident strobe
      strobe(300, 2);
      x_in = 777; sam_clk_ena = 1'b1; flush = 1'b1;
      tick();
      idle(5);
      strobe(5, 4);
      idle(8);

      // Saturation at both rails
      for (int n = 0; n < NT; n++) wr(n, 131071);
      repeat (5) strobe(131071, 4);
      repeat (5) strobe(-131072, 4);
      idle(8);

      // Rounding around half an LSB
      for (int n = 0; n < NT; n++) wr(n, (n == 0) ? 65536 : 0);
      strobe(1, 4);
      strobe(-1, 4);
      strobe(0, 4);
      strobe(3, 4);
      strobe(-3, 4);
      idle(8);

      // Random full-range coefficients and samples, random strobe spacing
      for (int n = 0; n < NT; n++) begin
         rv = DW'($urandom);
         wr(n, longint'(rv));
      end
      for (int i = 0; i < 150; i++) begin
         rv = DW'($urandom);
         strobe(longint'(rv), $urandom_range(1, 6));
      end
      idle(8);

      // Random small values keep the unshifted instance out of saturation
      for (int n = 0; n < NT; n++) wr(n, longint'($urandom_range(0, 127)) - 64);
      for (int i = 0; i < 150; i++)
         strobe(longint'($urandom_range(0, 127)) - 64, $urandom_range(1, 6));
      idle(3);

      // Asynchronous reset in the middle of a run wipes coefficients too
      strobe(40, 2);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_y_s0", y0, 0);
      chk("arst_v_s0", v0, 0);
      chk("arst_y_s17", y17, 0);
      chk("arst_v_s17", v17, 0);
      model_clear();
      tick();
      reset_n = 1'b1;
      idle(2);
      strobe(1, 4);
      repeat (5) strobe(0, 4);
      idle(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
